// File: rtl/flit_fixed_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// flit_fixed_traffic_gen_pkg
// Shared types, widths, LFSR taps and helper functions for the fixed-lane
// synthetic traffic generator.
//   - traffic_gen_state_e : generator FSM states
//   - flit_fixed_t        : 33-bit FlitFixed payload {time stamp, data}
//   - send_decision()     : per-cycle injection decision
//   - *_lfsr_next()       : one Fibonacci shift-left step of each LFSR
//   - *_seed_load()       : seed fixup (an all-zero seed would lock the LFSR)
// ---------------------------------------------------------------------------
package flit_fixed_traffic_gen_pkg;

  localparam int FLIT_W      = 33;
  localparam int STAMP_W     = 18;
  localparam int DATA_W      = 15;
  localparam int TIME_W      = 40;
  localparam int COUNT_W     = 31;
  localparam int SEND_LFSR_W = 20;
  localparam int THRESH_W    = 10;

  // Send LFSR: x^20 + x^17 + 1 ; data LFSR: x^15 + x^14 + 1 (bit indices).
  localparam int SEND_TAP_HI = 19;
  localparam int SEND_TAP_LO = 16;
  localparam int DATA_TAP_HI = 14;
  localparam int DATA_TAP_LO = 13;

  typedef enum logic [1:0] {
    TG_IDLE  = 2'd0,
    TG_GEN   = 2'd1,
    TG_DRAIN = 2'd2,
    TG_DONE  = 2'd3
  } traffic_gen_state_e;

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [DATA_W-1:0]  data;
  } flit_fixed_t;

  // All-ones threshold means "always", independent of the LFSR value.
  function automatic logic send_decision(input logic [THRESH_W-1:0] lfsr_low,
                                         input logic [THRESH_W-1:0] threshold);
    return (threshold == 10'h3FF) || (lfsr_low < threshold);
  endfunction

  function automatic logic [SEND_LFSR_W-1:0] send_lfsr_next(input logic [SEND_LFSR_W-1:0] lfsr);
    return {lfsr[SEND_LFSR_W-2:0], lfsr[SEND_TAP_HI] ^ lfsr[SEND_TAP_LO]};
  endfunction

  function automatic logic [DATA_W-1:0] data_lfsr_next(input logic [DATA_W-1:0] lfsr);
    return {lfsr[DATA_W-2:0], lfsr[DATA_TAP_HI] ^ lfsr[DATA_TAP_LO]};
  endfunction

  function automatic logic [SEND_LFSR_W-1:0] send_seed_load(input logic [SEND_LFSR_W-1:0] seed);
    return (seed == 20'd0) ? 20'd1 : seed;
  endfunction

  function automatic logic [DATA_W-1:0] data_seed_load(input logic [DATA_W-1:0] seed);
    return (seed == 15'd0) ? 15'd1 : seed;
  endfunction

endpackage

// File: rtl/flit_fixed_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// flit_fixed_traffic_gen_if
// Injection link between the traffic generator and the router LOCAL port.
//   flit_out       : FlitFixed payload (generator -> router)
//   flit_valid_out : payload valid this cycle (generator -> router)
//   credit_in      : one returned input-buffer credit (router -> generator)
// master = generator side, slave = router side.
// ---------------------------------------------------------------------------
interface flit_fixed_traffic_gen_if;
  import flit_fixed_traffic_gen_pkg::*;

  flit_fixed_t flit_out;
  logic        flit_valid_out;
  logic        credit_in;

  modport master (
    output flit_out,
    output flit_valid_out,
    input  credit_in
  );

  modport slave (
    input  flit_out,
    input  flit_valid_out,
    output credit_in
  );

endinterface

// File: rtl/flit_fixed_traffic_gen_chk.sv
// ---------------------------------------------------------------------------
// flit_fixed_traffic_gen_chk
// Simulation checker for the generator's credit counter.
//   clk_i, reset_i : clock and synchronous reset of the generator
//   credit_i       : returned credit this cycle
//   fire_i         : generator sends a flit this cycle
//   credits_i      : current credit count
// ---------------------------------------------------------------------------
module flit_fixed_traffic_gen_chk #(
  parameter int NUM_CREDITS = 4,
  parameter int CREDIT_W    = 3
) (
  input logic                clk_i,
  input logic                reset_i,
  input logic                credit_i,
  input logic                fire_i,
  input logic [CREDIT_W-1:0] credits_i
);

  // A credit returned without a matching send must not exceed the buffer depth.
  always @(posedge clk_i) begin
    if (!reset_i && credit_i && !fire_i) begin
      assert (credits_i < CREDIT_W'(NUM_CREDITS))
        else $error("credit counter overflow: credit returned with %0d credits held", credits_i);
    end
  end

endmodule

// File: rtl/flit_fixed_traffic_gen_src_fifo.sv
// ---------------------------------------------------------------------------
// flit_src_fifo
// Small synchronous source queue with simultaneous push/pop. A push while
// full is accepted when a pop happens in the same cycle.
//   clk, reset   : clock, synchronous active-high reset (empties queue)
//   push_i       : write request, push_data_i : write data
//   pop_i        : read request, pop_data_o : head entry (combinational)
//   full_o       : queue holds DEPTH entries, empty_o : queue holds none
// DEPTH must be a power of two (pointers wrap naturally).
// ---------------------------------------------------------------------------
module flit_src_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == {CW{1'b0}});
  assign rd_en      = pop_i && !empty_o;
  assign wr_en      = push_i && (!full_o || rd_en);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Occupancy next-state from the accepted write/read pair.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flit_fixed_traffic_gen.sv
// ---------------------------------------------------------------------------
// flit_fixed_traffic_gen
// Per-lane synthetic traffic source for one router LOCAL input port. While
// generating, a send LFSR decides each cycle whether to create a FlitFixed
// {cur_time[17:0], data_lfsr}; flits are queued and injected under
// credit-based flow control.
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse, leaves IDLE and relatches the seeds
//   send_seed/data_seed : LFSR seeds (zero seed loads 1)
//   send_threshold      : injection rate (0 never, 10'h3FF every cycle)
//   max_num_flits_sent  : generated-flit limit
//   max_gen_time        : generation-cycle limit
//   tx (master)         : flit_out / flit_valid_out / credit_in link
//   num_flits_sent      : flits injected
//   num_flits_dropped   : decisions lost to a full queue
//   cur_time            : generation-cycle counter
//   done                : generation finished and queue drained
// ---------------------------------------------------------------------------
module flit_fixed_traffic_gen
  import flit_fixed_traffic_gen_pkg::*;
#(
  parameter int SRC_Q_DEPTH = 4,
  parameter int NUM_CREDITS = 4,
  parameter int CREDIT_W    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SEND_LFSR_W-1:0] send_seed,
  input  logic [DATA_W-1:0]      data_seed,
  input  logic [THRESH_W-1:0]    send_threshold,
  input  logic [COUNT_W-1:0]     max_num_flits_sent,
  input  logic [TIME_W-1:0]      max_gen_time,
  flit_fixed_traffic_gen_if.master tx,
  output logic [COUNT_W-1:0]     num_flits_sent,
  output logic [COUNT_W-1:0]     num_flits_dropped,
  output logic [TIME_W-1:0]      cur_time,
  output logic                   done
);

  traffic_gen_state_e     state_q, state_d;
  logic [SEND_LFSR_W-1:0] send_lfsr_q, send_lfsr_d;
  logic [DATA_W-1:0]      data_lfsr_q, data_lfsr_d;
  logic [TIME_W-1:0]      cur_time_q, cur_time_d;
  logic [COUNT_W-1:0]     gen_count_q, gen_count_d;
  logic [COUNT_W-1:0]     sent_q, sent_d;
  logic [COUNT_W-1:0]     dropped_q, dropped_d;
  logic [CREDIT_W-1:0]    credits_q, credits_d;
  flit_fixed_t            flit_q, flit_d;
  logic                   flit_valid_q, flit_valid_d;
  logic                   done_q, done_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FLIT_W-1:0]      fifo_head;
  logic [FLIT_W-1:0]      new_flit;
  logic                   injecting;
  logic                   fire;
  logic                   decision;
  logic                   push;
  logic                   drop;

  assign injecting = (state_q == TG_GEN) || (state_q == TG_DRAIN);
  assign fire      = injecting && !fifo_empty && (credits_q != {CREDIT_W{1'b0}});
  assign decision  = (state_q == TG_GEN) && send_decision(send_lfsr_q[THRESH_W-1:0], send_threshold);
  // A full queue still accepts a flit when the head leaves in the same cycle.
  assign push      = decision && (!fifo_full || fire);
  assign drop      = decision && fifo_full && !fire;
  assign new_flit  = {cur_time_q[STAMP_W-1:0], data_lfsr_q};

  flit_src_fifo #(
    .DEPTH (SRC_Q_DEPTH),
    .WIDTH (FLIT_W)
  ) u_src_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (new_flit),
    .pop_i       (fire),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // FSM, generation counters and LFSR next-state.
  always_comb begin
    state_d     = state_q;
    send_lfsr_d = send_lfsr_q;
    data_lfsr_d = data_lfsr_q;
    cur_time_d  = cur_time_q;
    gen_count_d = gen_count_q;
    dropped_d   = dropped_q;
    sent_d      = sent_q;
    case (state_q)
      TG_IDLE: begin
        if (start) begin
          state_d     = TG_GEN;
          send_lfsr_d = send_seed_load(send_seed);
          data_lfsr_d = data_seed_load(data_seed);
          cur_time_d  = {TIME_W{1'b0}};
          gen_count_d = {COUNT_W{1'b0}};
          dropped_d   = {COUNT_W{1'b0}};
          sent_d      = {COUNT_W{1'b0}};
        end else begin
          state_d = TG_IDLE;
        end
      end
      TG_GEN: begin
        cur_time_d  = cur_time_q + 40'd1;
        send_lfsr_d = send_lfsr_next(send_lfsr_q);
        if (push) begin
          data_lfsr_d = data_lfsr_next(data_lfsr_q);
          gen_count_d = gen_count_q + 31'd1;
        end else begin
          data_lfsr_d = data_lfsr_q;
          gen_count_d = gen_count_q;
        end
        if (drop) begin
          dropped_d = dropped_q + 31'd1;
        end else begin
          dropped_d = dropped_q;
        end
        // Limits are checked against this cycle's updated values.
        if ((gen_count_d >= max_num_flits_sent) || (cur_time_d >= max_gen_time)) begin
          state_d = TG_DRAIN;
        end else begin
          state_d = TG_GEN;
        end
      end
      TG_DRAIN: begin
        // The last flit must have left the output register too.
        if (fifo_empty && !flit_valid_q) begin
          state_d = TG_DONE;
        end else begin
          state_d = TG_DRAIN;
        end
      end
      TG_DONE: begin
        state_d = TG_DONE;
      end
      default: begin
        state_d = TG_IDLE;
      end
    endcase
    if (fire) begin
      sent_d = sent_q + 31'd1;
    end else begin
      sent_d = sent_d;
    end
  end

  // Output register, credit counter and done flag next-state.
  always_comb begin
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    credits_d    = credits_q;
    if (fire) begin
      flit_d       = flit_fixed_t'(fifo_head);
      flit_valid_d = 1'b1;
    end else begin
      flit_d       = flit_q;
      flit_valid_d = 1'b0;
    end
    // A returned credit and a send in the same cycle cancel out.
    case ({fire, tx.credit_in})
      2'b10: credits_d = credits_q - CREDIT_W'(1);
      2'b01: begin
        if (credits_q < CREDIT_W'(NUM_CREDITS)) begin
          credits_d = credits_q + CREDIT_W'(1);
        end else begin
          credits_d = credits_q;
        end
      end
      default: credits_d = credits_q;
    endcase
    done_d = (state_d == TG_DONE);
  end

  // State registers; reset aborts any run and reloads the seeds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TG_IDLE;
      send_lfsr_q  <= send_seed_load(send_seed);
      data_lfsr_q  <= data_seed_load(data_seed);
      cur_time_q   <= {TIME_W{1'b0}};
      gen_count_q  <= {COUNT_W{1'b0}};
      sent_q       <= {COUNT_W{1'b0}};
      dropped_q    <= {COUNT_W{1'b0}};
      credits_q    <= CREDIT_W'(NUM_CREDITS);
      flit_q       <= flit_fixed_t'({FLIT_W{1'b0}});
      flit_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      send_lfsr_q  <= send_lfsr_d;
      data_lfsr_q  <= data_lfsr_d;
      cur_time_q   <= cur_time_d;
      gen_count_q  <= gen_count_d;
      sent_q       <= sent_d;
      dropped_q    <= dropped_d;
      credits_q    <= credits_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      done_q       <= done_d;
    end
  end

  flit_fixed_traffic_gen_chk #(
    .NUM_CREDITS (NUM_CREDITS),
    .CREDIT_W    (CREDIT_W)
  ) u_chk (
    .clk_i     (clk),
    .reset_i   (reset),
    .credit_i  (tx.credit_in),
    .fire_i    (fire),
    .credits_i (credits_q)
  );

  assign tx.flit_out        = flit_q;
  assign tx.flit_valid_out  = flit_valid_q;
  assign num_flits_sent     = sent_q;
  assign num_flits_dropped  = dropped_q;
  assign cur_time           = cur_time_q;
  assign done               = done_q;

endmodule

// File: doc/flit_fixed_traffic_gen.md
Name: flit_fixed_traffic_gen

Overview:
- Per-lane synthetic traffic source feeding one fixed-lane router input port (LOCAL injection).
- Uses TrafficConfig/LFSRConfig fields (send_threshold, max_num_flits_sent, max_gen_time, send_seed, data_seed) to decide, every cycle, whether to generate a FlitFixed.
- Buffers generated flits in a small source queue and injects them under credit-based flow control.
- Reports sent/dropped counts and a done flag for the testbench/host.

Parameters:
- SRC_Q_DEPTH, 4, source queue entries (power of 2, >=2)
- NUM_CREDITS, 4, downstream input-buffer depth; initial credit count
- CREDIT_W, 3, credit counter width; must hold NUM_CREDITS

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  pulse; leaves IDLE
- send_seed  in  20  send-LFSR seed
- data_seed  in  15  data-LFSR seed
- send_threshold  in  10  injection rate; 0 = never, 10'h3FF = every cycle
- max_num_flits_sent  in  31  generation limit
- max_gen_time  in  40  cycle limit for generation (Time)
- credit_in  in  1  one returned downstream credit (Credit)
- flit_out  out  33  FlitFixed payload
- flit_valid_out  out  1  flit_out valid this cycle
- num_flits_sent  out  31  flits injected
- num_flits_dropped  out  31  decisions lost to full queue
- cur_time  out  40  generation-cycle counter
- done  out  1  generation finished and queue drained

Behaviour:
- Reset:
  - Outputs 0; state IDLE; credits = NUM_CREDITS; queue empty.
  - LFSRs load seeds; an all-zero seed loads 1.
  - A reset mid-run aborts immediately; queued flits are discarded.
- FSM:
  - IDLE -> GEN on start (seeds relatched on start).
  - GEN -> DRAIN when generated count == max_num_flits_sent, or when cur_time == max_gen_time.
  - DRAIN -> DONE when the queue is empty and no flit is in the output register.
  - DONE holds done=1 until reset; start is ignored outside IDLE.
- GEN, each cycle:
  - cur_time increments (40-bit, no wrap expected).
  - Send LFSR (x^20+x^17+1, Fibonacci, shift left) advances.
  - decision = (send_threshold==10'h3FF) | (send_lfsr[9:0] < send_threshold).
- On decision:
  - If the queue is not full: enqueue {cur_time[17:0], data_lfsr[14:0]}, advance data LFSR (x^15+x^14+1), increment generated count.
  - If the queue is full: increment num_flits_dropped; generated count is unchanged; data LFSR does not advance.
  - The limit check uses the count after the current cycle's update.
- Injection (GEN and DRAIN):
  - Fire when queue non-empty and credits>0.
  - On the fire edge: flit_out <= head, flit_valid_out <= 1, pop, credits--, num_flits_sent++.
  - Otherwise flit_valid_out <= 0; flit_out holds its value.
- Latency: decision in cycle t -> flit_valid_out in cycle t+2 (empty queue, credits available). Queue write and pop in the same cycle are allowed, including at full.
- Credits:
  - credit_in at cycle t increments at the edge; usable at t+1.
  - credit_in together with a send: count unchanged.
  - Count never exceeds NUM_CREDITS (overflow is an assertion failure in sim).
- credit_in is accepted in every state except reset.

Decomposition:
- Add to SMARTPkg:
  - TrafficGenState enum {TG_IDLE, TG_GEN, TG_DRAIN, TG_DONE}.
  - LFSR tap constants.
  - Function send_decision(lfsr, threshold).
- Sub-module: flit_src_fifo (parameterised depth/width, sync reset, full/empty, simultaneous push/pop).

Test Plan:
- threshold=3FF, max_flits=6, NUM_CREDITS=4, credit_in returned 1 cycle after each flit -> valid from cycle 2 after start; 6 flits sent; dropped=0; done.
- threshold=3FF, max_flits=10, no credit_in -> exactly 4 flits sent, queue fills, later decisions dropped; state stays in GEN.
- threshold=0, max_gen_time=50 -> no flits; cur_time reaches 50; done at the next cycle.
- Simultaneous credit_in and send with credits=1 -> send occurs; credits stay 1; the next send is allowed.
- Reset asserted in DRAIN with 2 queued flits -> next cycle valid=0, counts 0, state IDLE.
- send_seed=0 -> LFSR loads 1; flit data matches the reference model sequence from seed 1.
